// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared types and constants for the nibble parity path
//
// Purpose: state encoding for the parity-check FSM, default counter width
// and the parity-sense constants used by both the checker and the upstream
// parity generator.
// Ports: none (package).

package parity_pkg;

  localparam int CNT_W_DEFAULT = 8;

  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC    = 2'd1,
    REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/xor4_parity.sv
// rtl/xor4_parity.sv - combinational 4-bit XOR parity reduction
//
// Purpose: computes the even parity of a nibble. Shared with the upstream
// parity generator so both ends use the same bit ordering.
// Ports:
//   data_i  in  4  nibble, bit 0 is the first operand of the XOR chain
//   p_o     out 1  XOR of all four data bits

module xor4_parity (
  input  logic [3:0] data_i,
  output logic       p_o
);

  assign p_o = ((data_i[0] ^ data_i[1]) ^ data_i[2]) ^ data_i[3];

endmodule

// File: rtl/nibble_parity_checker.sv
// rtl/nibble_parity_checker.sv - per-frame nibble parity checker with summary output
//
// Purpose: recomputes each accepted nibble's parity, compares it with the
// transmitted bit, and accumulates saturating length / bad-nibble counts
// per frame. One summary record is emitted per frame after the in_last beat.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             input beat handshake
//   in_data[3:0], in_par, in_last nibble, transmitted parity, end-of-frame
//   out_valid/out_ready           summary record handshake
//   out_err                       frame contained at least one bad nibble
//   out_len[CNT_W-1:0]            nibbles in frame (saturating)
//   out_bad[CNT_W-1:0]            bad nibbles in frame (saturating)

module nibble_parity_checker
  import parity_pkg::*;
#(
  parameter bit ODD   = PAR_EVEN,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  input  logic             in_par,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_err,
  output logic [CNT_W-1:0] out_len,
  output logic [CNT_W-1:0] out_bad
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] bad_q, bad_d;

  logic p;
  logic bad_beat;
  logic accept;
  logic take;

  xor4_parity u_xor4_parity (
    .data_i (in_data),
    .p_o    (p)
  );

  assign bad_beat = (in_par != (p ^ ODD));

  // Handshake outputs decode only registered state, so neither in_valid nor
  // out_ready has a combinational path to the opposite handshake.
  assign in_ready  = (state_q != REPORT);
  assign out_valid = (state_q == REPORT);
  assign accept    = in_valid && in_ready;
  assign take      = out_valid && out_ready;

  assign out_len = len_q;
  assign out_bad = bad_q;
  assign out_err = (bad_q != '0);

  // Next counter values for an accepted beat. The first beat of a frame
  // loads rather than adds. bad never exceeds len, so saturating each
  // independently preserves that ordering.
  always_comb begin
    len_d = len_q;
    bad_d = bad_q;
    if (state_q == IDLE) begin
      len_d = CNT_W'(1);
      bad_d = CNT_W'(bad_beat);
    end else begin
      if (len_q != CNT_MAX) begin
        len_d = len_q + CNT_W'(1);
      end
      if (bad_beat && (bad_q != CNT_MAX)) begin
        bad_d = bad_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      bad_q   <= '0;
    end else begin
      case (state_q)
        IDLE, ACC: begin
          if (accept) begin
            len_q   <= len_d;
            bad_q   <= bad_d;
            state_q <= in_last ? REPORT : ACC;
          end
        end
        REPORT: begin
          // Counters are left untouched so the record stays stable until taken.
          if (take) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_parity_checker.sv
// tb/tb_nibble_parity_checker.sv - self-checking bench for nibble_parity_checker

module tb_nibble_parity_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_par;
  logic       in_last;
  logic       out_ready;

  logic       in_ready_a, out_valid_a, out_err_a;
  logic [7:0] out_len_a, out_bad_a;
  logic       in_ready_b, out_valid_b, out_err_b;
  logic [7:0] out_len_b, out_bad_b;
  logic       in_ready_c, out_valid_c, out_err_c;
  logic [1:0] out_len_c, out_bad_c;

  int checks   = 0;
  int failures = 0;

  // Reference model: raw per-frame counts, saturated when compared.
  int m_len      = 0;
  int m_bad_even = 0;
  int m_bad_odd  = 0;

  int acc_cnt = 0;
  int rec_cnt = 0;

  always #5 clk = ~clk;

  // A: even parity, 8-bit counters. B: odd parity. C: even parity, 2-bit counters.
  nibble_parity_checker #(.ODD(1'b0), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_par(in_par), .in_last(in_last),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_err(out_err_a),
    .out_len(out_len_a), .out_bad(out_bad_a)
  );

  nibble_parity_checker #(.ODD(1'b1), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_par(in_par), .in_last(in_last),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_err(out_err_b),
    .out_len(out_len_b), .out_bad(out_bad_b)
  );

  nibble_parity_checker #(.ODD(1'b0), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
    .in_data(in_data), .in_par(in_par), .in_last(in_last),
    .out_valid(out_valid_c), .out_ready(out_ready), .out_err(out_err_c),
    .out_len(out_len_c), .out_bad(out_bad_c)
  );

  always @(posedge clk) begin
    if (!rst && in_valid && in_ready_a) acc_cnt++;
    if (!rst && out_valid_a && out_ready) rec_cnt++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic clear_model();
    m_len      = 0;
    m_bad_even = 0;
    m_bad_odd  = 0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready_a"}, int'(in_ready_a), 1);
    chk({tag, "_ready_b"}, int'(in_ready_b), 1);
    chk({tag, "_ready_c"}, int'(in_ready_c), 1);
    chk({tag, "_valid_a"}, int'(out_valid_a), 0);
    chk({tag, "_valid_b"}, int'(out_valid_b), 0);
    chk({tag, "_valid_c"}, int'(out_valid_c), 0);
    chk({tag, "_err_a"}, int'(out_err_a), 0);
    chk({tag, "_len_a"}, int'(out_len_a), 0);
    chk({tag, "_bad_a"}, int'(out_bad_a), 0);
    chk({tag, "_len_c"}, int'(out_len_c), 0);
    chk({tag, "_bad_c"}, int'(out_bad_c), 0);
  endtask

  // Record presented on all three instances must match the model.
  task automatic check_rec(input string tag);
    int la, ba, bb, lc, bc;
    la = sat(m_len, 8);
    ba = sat(m_bad_even, 8);
    bb = sat(m_bad_odd, 8);
    lc = sat(m_len, 2);
    bc = sat(m_bad_even, 2);
    chk({tag, "_valid_a"}, int'(out_valid_a), 1);
    chk({tag, "_valid_b"}, int'(out_valid_b), 1);
    chk({tag, "_valid_c"}, int'(out_valid_c), 1);
    chk({tag, "_ready_a"}, int'(in_ready_a), 0);
    chk({tag, "_ready_c"}, int'(in_ready_c), 0);
    chk({tag, "_len_a"}, int'(out_len_a), la);
    chk({tag, "_bad_a"}, int'(out_bad_a), ba);
    chk({tag, "_err_a"}, int'(out_err_a), int'(ba != 0));
    chk({tag, "_len_b"}, int'(out_len_b), la);
    chk({tag, "_bad_b"}, int'(out_bad_b), bb);
    chk({tag, "_err_b"}, int'(out_err_b), int'(bb != 0));
    chk({tag, "_len_c"}, int'(out_len_c), lc);
    chk({tag, "_bad_c"}, int'(out_bad_c), bc);
    chk({tag, "_err_c"}, int'(out_err_c), int'(bc != 0));
  endtask

  // Presents one beat, waits (bounded) for in_ready, and updates the model
  // on the accepting edge. waited reports cycles spent with in_ready low.
  task automatic beat(input logic [3:0] d, input logic p, input logic last, output int waited);
    waited   = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_par   = p;
    in_last  = last;
    while (!in_ready_a && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 20) chk("beat_ready_timeout", waited, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    m_len++;
    if (p != ^d) m_bad_even++;
    if (p == ^d) m_bad_odd++;
  endtask

  // Called right after the in_last beat is accepted: record must already be
  // up, hold for `hold` cycles of backpressure, then be taken.
  task automatic finish_frame(input string tag, input int hold);
    check_rec(tag);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_rec({tag, "_hold"});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ready_after"}, int'(in_ready_a), 1);
    chk({tag, "_valid_after"}, int'(out_valid_a), 0);
    clear_model();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int w, r0, a0, nb;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    in_par    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;

    // Even parity, clean 3-beat frame.
    beat(4'b1011, 1'b1, 1'b0, w);
    beat(4'b0000, 1'b0, 1'b0, w);
    beat(4'b1111, 1'b0, 1'b1, w);
    chk("even3_len_const", int'(out_len_a), 3);
    chk("even3_bad_const", int'(out_bad_a), 0);
    finish_frame("even3", 0);

    // Beats 1 and 3 flipped, 5 cycles of backpressure.
    beat(4'b1011, 1'b0, 1'b0, w);
    beat(4'b0000, 1'b0, 1'b0, w);
    beat(4'b1111, 1'b1, 1'b1, w);
    chk("err3_bad_const", int'(out_bad_a), 2);
    finish_frame("err3", 5);

    // Single-beat frames; instance B is the odd-parity case.
    beat(4'b0001, 1'b0, 1'b1, w);
    chk("odd1_bad_const", int'(out_bad_b), 0);
    finish_frame("single_p0", 0);
    beat(4'b0001, 1'b1, 1'b1, w);
    chk("odd1b_bad_const", int'(out_bad_b), 1);
    finish_frame("single_p1", 1);

    // 6 bad beats: instance C saturates at 3.
    for (int k = 0; k < 6; k++) beat(4'b0001, 1'b0, logic'(k == 5), w);
    chk("sat_len_c_const", int'(out_len_c), 3);
    chk("sat_bad_c_const", int'(out_bad_c), 3);
    finish_frame("sat6", 0);

    // Reset mid-frame discards the partial frame.
    r0 = rec_cnt;
    beat(4'b0011, 1'b1, 1'b0, w);
    beat(4'b0111, 1'b0, 1'b0, w);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset("midrst");
    clear_model();
    beat(4'b0110, 1'b0, 1'b1, w);
    finish_frame("postrst", 0);
    chk("postrst_records", rec_cnt - r0, 1);

    // Back-to-back 2-beat frames with out_ready held high.
    r0 = rec_cnt;
    a0 = acc_cnt;
    out_ready = 1'b1;
    beat(4'h3, 1'b0, 1'b0, w);
    beat(4'h5, 1'b1, 1'b1, w);
    check_rec("b2b1");
    clear_model();
    beat(4'h6, 1'b0, 1'b0, w);
    chk("b2b_gap", w, 1);
    beat(4'h9, 1'b1, 1'b1, w);
    check_rec("b2b2");
    clear_model();
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b_ready_after", int'(in_ready_a), 1);
    chk("b2b_records", rec_cnt - r0, 2);
    chk("b2b_beats", acc_cnt - a0, 4);

    // Random frames against the model.
    for (int f = 0; f < 20; f++) begin
      nb = int'($urandom_range(1, 7));
      for (int k = 0; k < nb; k++) begin
        beat(4'($urandom), 1'($urandom), logic'(k == nb - 1), w);
      end
      finish_frame("rnd", int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
